busio: RTL and testbench

- Bus interface unit directly upstream of the pipeline top.
- Serves the pipeline's fetch port (instruction reads) and memory port (data loads/stores) over one shared single-outstanding external bus.
- Generates fetch_ready/mem_ready for hazard control.
- Handles byte-lane alignment, store strobes and load sign/zero extension, so the pipeline sees word-clean data.

---
 rtl/busio_pkg.sv | 31 +++
 rtl/busio_lane.sv | 40 ++++
 rtl/busio.sv | 149 ++++++++++++++
 tb/tb_busio.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busio_pkg.sv
// Shared encodings for the bus interface unit: access sizes, strobes, FSM states
// and the natural-alignment helpers used by busio and busio_lane.
package busio_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MEM   = 2'd2
  } state_t;

  // Low address bits snapped to the natural alignment of the access size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return a;
      SIZE_HALF: return {a[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SIZE_HALF) && a[0]) || (size[1] && (a != 2'b00));
  endfunction
endpackage

// File: rtl/busio_lane.sv
// Byte-lane steering: store strobes and replication, load extraction and
// sign/zero extension. Purely combinational; i_off must already be aligned.
module busio_lane
  import busio_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_store,
  input  logic        i_signed,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_read_data,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_write_data,
  output logic [31:0] o_load_data
);
  logic [31:0] w_rsh;
  logic [3:0]  w_strb;

  assign w_rsh = i_read_data >> {i_off, 3'b000};

  always_comb begin
    w_strb       = STRB_WORD;
    o_write_data = i_store_data;
    o_load_data  = i_read_data;
    case (i_size)
      SIZE_BYTE: begin
        w_strb       = STRB_BYTE << i_off;
        o_write_data = {4{i_store_data[7:0]}};
        o_load_data  = {{24{i_signed & w_rsh[7]}}, w_rsh[7:0]};
      end
      SIZE_HALF: begin
        w_strb       = STRB_HALF << i_off;
        o_write_data = {2{i_store_data[15:0]}};
        o_load_data  = {{16{i_signed & w_rsh[15]}}, w_rsh[15:0]};
      end
      default: ;
    endcase
    o_strobe = i_store ? w_strb : STRB_NONE;
  end
endmodule

// File: rtl/busio.sv
// Bus interface unit: arbitrates fetch and memory-stage accesses onto one
// single-outstanding bus. Optional BUSIO_MISALIGN_CHECK_EN traps misaligned accesses.
module busio
  import busio_pkg::*;
#(
  parameter logic RESET_FETCH_VALID = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        mem_advance,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        mem_misaligned,
  output logic [31:0] ext_address,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  output logic        ext_instruction,
  output logic        ext_valid,
  input  logic        ext_ready,
  input  logic [31:0] ext_read_data
);
  state_t      r_state, w_state_nx;
  logic        r_fbuf_valid;
  logic [29:0] r_fbuf_addr;
  logic [31:0] r_fbuf_data;
  logic        r_mdone, r_misal;
  logic [31:0] r_load_data;
  logic [31:0] r_ext_address, r_ext_write_data;
  logic [3:0]  r_ext_strobe;

  logic        w_mem_req, w_fetch_cmp, w_mem_cmp, w_decide, w_fhit;
  logic        w_misal, w_issue_mem, w_mis_set;
  logic [1:0]  w_off;
  logic [3:0]  w_strobe;
  logic [31:0] w_wdata, w_ldata;
  logic        w_unused;

  assign w_unused    = ^fetch_address[1:0];
  assign w_mem_req   = (mem_load | mem_store) & ~r_mdone;
  assign mem_ready   = r_mdone | ~(mem_load | mem_store);
  assign fetch_ready = r_fbuf_valid && (r_fbuf_addr == fetch_address[31:2]);
  assign fetch_data  = r_fbuf_data;
  assign w_fetch_cmp = (r_state == FETCH) && ext_ready;
  assign w_mem_cmp   = (r_state == MEM) && ext_ready;
  assign w_decide    = (r_state == IDLE) || w_fetch_cmp || w_mem_cmp;
  // A fetch completing this cycle counts as a hit so the same word is not refetched.
  assign w_fhit      = fetch_ready ||
                       (w_fetch_cmp && (r_ext_address[31:2] == fetch_address[31:2]));
  assign w_off       = align_off(mem_size, mem_address[1:0]);

`ifdef BUSIO_MISALIGN_CHECK_EN
  assign w_misal = is_misaligned(mem_size, mem_address[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  // The request completing now has mdone about to set, so it must not re-issue.
  assign w_issue_mem    = w_mem_req && !w_misal && !w_mem_cmp;
  assign w_mis_set      = w_mem_req && w_misal && (r_state != MEM);
  assign mem_misaligned = r_mdone & r_misal;
  assign mem_load_data  = r_load_data;

  assign ext_valid        = (r_state != IDLE);
  assign ext_instruction  = (r_state == FETCH);
  assign ext_address      = r_ext_address;
  assign ext_write_data   = r_ext_write_data;
  assign ext_write_strobe = r_ext_strobe;

  busio_lane u_lane (
    .i_size       (mem_size),
    .i_off        (w_off),
    .i_store      (mem_store),
    .i_signed     (mem_signed),
    .i_store_data (mem_store_data),
    .i_read_data  (ext_read_data),
    .o_strobe     (w_strobe),
    .o_write_data (w_wdata),
    .o_load_data  (w_ldata)
  );

  always_comb begin
    w_state_nx = r_state;
    if (w_decide) begin
      if (w_issue_mem)  w_state_nx = MEM;
      else if (!w_fhit) w_state_nx = FETCH;
      else              w_state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_address    <= '0;
      r_ext_write_data <= '0;
      r_ext_strobe     <= STRB_NONE;
    end else if (w_decide && (w_state_nx == MEM)) begin
      r_ext_address    <= {mem_address[31:2], 2'b00};
      r_ext_write_data <= w_wdata;
      r_ext_strobe     <= w_strobe;
    end else if (w_decide && (w_state_nx == FETCH)) begin
      r_ext_address    <= {fetch_address[31:2], 2'b00};
      r_ext_strobe     <= STRB_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fbuf_valid <= RESET_FETCH_VALID;
      r_fbuf_addr  <= '0;
      r_fbuf_data  <= '0;
    end else if (w_fetch_cmp) begin
      r_fbuf_valid <= 1'b1;
      r_fbuf_addr  <= r_ext_address[31:2];
      r_fbuf_data  <= ext_read_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mdone     <= 1'b0;
      r_misal     <= 1'b0;
      r_load_data <= '0;
    end else if (w_mem_cmp) begin
      r_mdone <= 1'b1;
      r_misal <= 1'b0;
      if (mem_load && !mem_store) r_load_data <= w_ldata;
    end else if (w_mis_set) begin
      r_mdone     <= 1'b1;
      r_misal     <= 1'b1;
      r_load_data <= '0;
    end else if (mem_advance) begin
      r_mdone <= 1'b0;
      r_misal <= 1'b0;
    end
  end
endmodule

// File: tb/tb_busio.sv
// Scoreboard bench for busio: a byte-array memory model predicts bus transactions,
// fetch words and load results; monitors pop and compare as the DUT presents them.
module tb_busio;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_address = '0, fetch_data;
  logic        fetch_ready;
  logic [31:0] mem_address = '0, mem_store_data = '0, mem_load_data;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 0, mem_load = 0, mem_store = 0, mem_advance = 0;
  logic        mem_ready, mem_misaligned;
  logic [31:0] ext_address, ext_write_data, ext_read_data;
  logic [3:0]  ext_write_strobe;
  logic        ext_instruction, ext_valid, ext_ready;

  always #5 clk = ~clk;

  busio dut (
    .clk(clk), .reset(reset),
    .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
    .mem_advance(mem_advance), .mem_load_data(mem_load_data), .mem_ready(mem_ready),
    .mem_misaligned(mem_misaligned), .ext_address(ext_address),
    .ext_write_data(ext_write_data), .ext_write_strobe(ext_write_strobe),
    .ext_instruction(ext_instruction), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_read_data(ext_read_data)
  );

`ifdef BUSIO_MISALIGN_CHECK_EN
  localparam bit TB_ALIGN = 1'b1;
`else
  localparam bit TB_ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        instr;
  } btx_t;

  int errors = 0, checks = 0;
  btx_t        exp_bus[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_load[$];
  logic [31:0] smem [0:4095];
  logic [7:0]  rmem [0:16383];
  int   wmax = 0, wfix = -1;
  bit   stall = 0, fvalid = 0, mseen = 0;
  logic [29:0] fbuf_m = '0;
  logic        prev_fr = 0;
  logic [31:0] prev_fa = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] a, input logic [1:0] sz);
    return a & ~(nbytes(sz) - 1);
  endfunction

  function automatic logic [31:0] rword(input logic [31:0] a);
    logic [31:0] w;
    int base = {18'd0, a[13:2], 2'b00};
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rmem[base + k];
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    smem[a[13:2]] = w;
    for (int k = 0; k < 4; k++) rmem[{18'd0, a[13:2], 2'b00} + k] = w[8*k +: 8];
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          input logic ins);
    btx_t t;
    t.addr = a; t.strb = s; t.wdata = d; t.instr = ins;
    exp_bus.push_back(t);
  endtask

  // Reference: stores write n little-endian bytes; loads gather and extend them.
  task automatic push_mem(input bit st, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] sd);
    logic [31:0] ea = eff(a, sz);
    int n = nbytes(sz);
    int base = {18'd0, ea[13:0]};
    logic [3:0]  s = '0;
    logic [31:0] v = '0, wd;
    if (st) begin
      for (int k = 0; k < n; k++) begin
        s[(ea[1:0] + k) % 4] = 1'b1;
        rmem[base + k] = sd[8*k +: 8];
      end
      wd = (n == 1) ? {4{sd[7:0]}} : (n == 2) ? {2{sd[15:0]}} : sd;
      push_bus({ea[31:2], 2'b00}, s, wd, 1'b0);
    end else begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = rmem[base + k];
      if (sg && v[8*n-1]) for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
      push_bus({ea[31:2], 2'b00}, 4'b0000, '0, 1'b0);
      exp_load.push_back(v);
    end
  endtask

  task automatic mem_start(input bit st, input bit ld, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] sd);
    push_mem(st, sz, sg, a, sd);
    mem_address = a; mem_size = sz; mem_signed = sg; mem_store_data = sd;
    mem_store = st; mem_load = ld;
  endtask

  task automatic fetch_start(input logic [31:0] a, input bit presented);
    if (!fvalid || fbuf_m != a[31:2]) begin
      push_bus({a[31:2], 2'b00}, 4'b0000, '0, 1'b1);
      if (presented) exp_fetch.push_back(rword(a));
    end
    fvalid = 1; fbuf_m = a[31:2];
    fetch_address = a;
  endtask

  task automatic wait_for(input int which, input int maxc, output int cyc);
    bit hit = 0;
    cyc = 0;
    while (!hit) begin
      @(negedge clk);
      case (which)
        0: hit = fetch_ready;
        1: hit = mem_ready;
        2: hit = fetch_ready && mem_ready;
        default: hit = ext_valid;
      endcase
      if (!hit) begin
        cyc++;
        if (cyc > maxc) begin
          checks++; errors++;
          $display("FAIL wait_timeout: condition %0d not seen within %0d cycles", which, maxc);
          hit = 1;
        end
      end
    end
  endtask

  task automatic mem_finish(input int stall_c);
    for (int s = 0; s < stall_c; s++) begin
      @(negedge clk);
      chk("mem_ready_held", {31'd0, mem_ready}, 32'd1);
    end
    @(posedge clk); #1 mem_advance = 1;
    @(posedge clk); #1 mem_advance = 0; mem_load = 0; mem_store = 0;
  endtask

  // Bus slave and bus-transaction monitor.
  initial begin : slave
    bit busy = 0;
    int wc = 0;
    btx_t t;
    ext_ready = 0; ext_read_data = '0;
    forever begin
      @(negedge clk);
      if (!ext_valid) begin
        busy = 0; ext_ready = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          wc = (wfix >= 0) ? wfix : $urandom_range(wmax, 0);
        end
        if (stall || wc > 0) begin
          ext_ready = 0;
          if (!stall) wc--;
        end else begin
          ext_ready = 1; busy = 0;
          ext_read_data = smem[ext_address[13:2]];
          for (int k = 0; k < 4; k++)
            if (ext_write_strobe[k]) smem[ext_address[13:2]][8*k +: 8] = ext_write_data[8*k +: 8];
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: addr %h strobe %h", ext_address, ext_write_strobe);
          end else begin
            t = exp_bus.pop_front();
            chk("bus_addr", ext_address, t.addr);
            chk("bus_strobe", {28'd0, ext_write_strobe}, {28'd0, t.strb});
            chk("bus_instr", {31'd0, ext_instruction}, {31'd0, t.instr});
            if (t.strb != 4'b0000) chk("bus_wdata", ext_write_data, t.wdata);
          end
        end
      end
    end
  end

  // Pipeline-side monitor: fetch words and load results.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        if (fetch_ready && (!prev_fr || fetch_address[31:2] != prev_fa[31:2])) begin
          if (exp_fetch.size() == 0) begin
            checks++; errors++;
            $display("FAIL fetch_unexpected: addr %h data %h", fetch_address, fetch_data);
          end else chk("fetch_data", fetch_data, exp_fetch.pop_front());
        end
        prev_fr = fetch_ready; prev_fa = fetch_address;
        if ((mem_load || mem_store) && mem_ready && !mseen) begin
          mseen = 1;
          chk("mem_misaligned", {31'd0, mem_misaligned}, 32'd0);
          if (mem_load && !mem_store) begin
            if (exp_load.size() == 0) begin
              checks++; errors++;
              $display("FAIL load_unexpected: data %h", mem_load_data);
            end else chk("load_data", mem_load_data, exp_load.pop_front());
          end
        end
        if (mem_advance) mseen = 0;
      end else begin
        prev_fr = 0; mseen = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c;
    logic [31:0] a, sd;
    logic [1:0]  sz;
    bit st, ld, sg;
    for (int i = 0; i < 4096; i++) set_word(32'(i * 4), $urandom);
    set_word(32'h100, 32'h0000_0013);
    set_word(32'h2010, 32'h8001_1234);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ext_valid", {31'd0, ext_valid}, 32'd0);
    chk("rst_ext_address", ext_address, 32'd0);
    chk("rst_ext_strobe", {28'd0, ext_write_strobe}, 32'd0);
    chk("rst_ext_wdata", ext_write_data, 32'd0);
    chk("rst_ext_instr", {31'd0, ext_instruction}, 32'd0);
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_load_data", mem_load_data, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_misaligned", {31'd0, mem_misaligned}, 32'd0);

    fetch_start(32'h0, 1);
    @(negedge clk) reset = 1;
    wait_for(0, 20, c);

    // Single fetch with explicit zero-wait latency, then no re-fetch.
    @(posedge clk); #1 fetch_start(32'h100, 1);
    @(negedge clk) chk("f100_c0_valid", {31'd0, ext_valid}, 32'd0);
    @(negedge clk) chk("f100_c1_valid", {30'd0, ext_valid, ext_instruction}, 32'd3);
    @(negedge clk) chk("f100_c2_ready", {31'd0, fetch_ready}, 32'd1);
    chk("f100_data", fetch_data, 32'h13);
    repeat (5) @(negedge clk);
    chk("f100_no_refetch", {31'd0, ext_valid}, 32'd0);

    // Memory request wins over a simultaneous fetch; fetch follows back-to-back.
    @(posedge clk); #1;
    mem_start(0, 1, 2'd2, 0, 32'h2000, '0);
    fetch_start(32'h104, 1);
    wait_for(2, 20, c);
    chk("simul_latency", 32'(c), 32'd3);
    mem_finish(0);

    // Byte store with the stage stalled: one transaction, mem_ready held.
    @(posedge clk); #1 mem_start(1, 0, 2'd0, 0, 32'h2003, 32'h1234_56AB);
    wait_for(1, 20, c);
    mem_finish(3);

    @(posedge clk); #1 mem_start(0, 1, 2'd1, 1, 32'h2012, '0);
    wait_for(1, 20, c);
    chk("half_signed", mem_load_data, 32'hFFFF_8001);
    mem_finish(0);
    @(posedge clk); #1 mem_start(0, 1, 2'd1, 0, 32'h2012, '0);
    wait_for(1, 20, c);
    chk("half_unsigned", mem_load_data, 32'h0000_8001);
    mem_finish(0);

    // Fetch redirected while the bus is slow.
    wfix = 2;
    @(posedge clk); #1 fetch_start(32'h200, 0);
    wait_for(3, 20, c);
    @(posedge clk); #1 fetch_start(32'h300, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("redirect_not_ready", {31'd0, fetch_ready}, 32'd0);
    end
    wait_for(0, 20, c);
    wfix = -1;

    // Reset while a memory transaction is on the bus.
    stall = 1;
    @(posedge clk); #1 mem_start(0, 1, 2'd2, 0, 32'h2000, '0);
    wait_for(3, 20, c);
    #2 reset = 0;
    #1 chk("rst_mid_valid", {31'd0, ext_valid}, 32'd0);
    chk("rst_mid_fready", {31'd0, fetch_ready}, 32'd0);
    exp_bus.delete(); exp_load.delete(); fvalid = 0;
    @(negedge clk) reset = 1;
    #1 chk("rst_rel_valid", {31'd0, ext_valid}, 32'd0);
    chk("rst_rel_mem_ready", {31'd0, mem_ready}, 32'd0);
    stall = 0;
    push_mem(0, 2'd2, 0, 32'h2000, '0);
    fetch_start(fetch_address, 1);
    wait_for(2, 30, c);
    mem_finish(0);

    // Randomized mix of fetches and memory accesses with random bus wait states.
    wmax = 3;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(2, 0) == 0) begin
        a = {24'd0, 6'($urandom_range(63, 0)), 2'($urandom_range(3, 0))};
        if (a[31:2] == fetch_address[31:2]) a = {24'd0, a[7:0] + 8'd4};
        fetch_start(a, 1);
        wait_for(0, 40, c);
      end else begin
        st = 1'($urandom_range(1, 0));
        ld = st ? ($urandom_range(3, 0) == 0) : 1'b1;
        sz = 2'($urandom_range(3, 0));
        sg = 1'($urandom_range(1, 0));
        a  = 32'h2000 + 32'($urandom_range(255, 0));
        if (TB_ALIGN) a = eff(a, sz);
        sd = $urandom;
        mem_start(st, ld, sz, sg, a, sd);
        wait_for(1, 40, c);
        mem_finish($urandom_range(2, 0));
      end
    end

    repeat (6) @(negedge clk);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
    chk("load_queue_drained", 32'(exp_load.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
